video_bank_sched: RTL

- Ping-pong scheduler for the two video memory banks (VIDEO_BANK1/VIDEO_BANK2).
- Decides which bank the SPI data path writes and which bank the VGA path reads.
- Drives chip_select to request the next payload from the PC, and issues switch_mode when the banks swap.
- Sits between the data FSM, the VGA timing block and the video controller, in the CLK_40 domain.

---
 rtl/video_bank_sched.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/video_bank_sched.sv
// video_bank_sched: ping-pong scheduler for the two video memory banks (CLK_40 domain).
// Chooses the SPI write bank and the VGA read bank. Drives chip_select payload requests and pulses switch_mode on each swap.
// Optional build macro VIDEO_BANK_SCHED_STATS_EN adds swap_count / underrun_count outputs.
module video_bank_sched #(
  parameter int FRAMES_PER_BANK = 15,
  parameter int FRAME_REPEAT    = 2,
  parameter int CS_GAP          = 40,
  parameter int IDX_W           = 4
) (
  input  logic             CLK_40,
  input  logic             reset,
  input  logic             start,
  input  logic             wr_frame_done,
  input  logic             vga_frame_end,
  output logic             chip_select,
  output logic             write_bank2,
  output logic             read_bank1,
  output logic             read_bank2,
  output logic             switch_mode,
  output logic [IDX_W-1:0] read_frame_idx,
  output logic [IDX_W-1:0] wr_count,
  output logic             underrun,
  output logic             overflow
`ifdef VIDEO_BANK_SCHED_STATS_EN
  ,
  output logic [15:0]      swap_count,
  output logic [7:0]       underrun_count
`endif
);

  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam int REP_W = (FRAME_REPEAT > 1) ? $clog2(FRAME_REPEAT) : 1;

  localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(FRAMES_PER_BANK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAMES_PER_BANK - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(FRAME_REPEAT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PLAY, S_STALL} state_e;

  state_e             state_q, state_d;
  logic               cs_q, cs_d;
  logic               wb2_q, wb2_d;
  logic               rb1_q, rb1_d;
  logic               rb2_q, rb2_d;
  logic               sw_q, sw_d;
  logic [IDX_W-1:0]   ridx_q, ridx_d;
  logic [IDX_W-1:0]   wcnt_q, wcnt_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               urun_q, urun_d;
  logic               ovf_q, ovf_d;
`ifdef VIDEO_BANK_SCHED_STATS_EN
  logic [15:0]        swap_cnt_q, swap_cnt_d;
  logic [7:0]         urun_cnt_q, urun_cnt_d;
`endif

  // Shared decode: the write increment is applied before the swap decision,
  // so a frame completing in the same cycle as vga_frame_end can enable a swap.
  logic             active;
  logic             wr_acc;
  logic             wr_ovf;
  logic [IDX_W-1:0] wcnt_inc;
  logic             bank_full;
  logic             rep_wrap;
  logic             last_frame;
  logic             do_swap;
  logic             do_stall;

  assign active     = (state_q != S_IDLE);
  assign wr_acc     = active && wr_frame_done && (wcnt_q != FULL_CNT);
  assign wr_ovf     = active && wr_frame_done && (wcnt_q == FULL_CNT);
  assign wcnt_inc   = wcnt_q + IDX_W'(wr_acc);
  assign bank_full  = (wcnt_inc == FULL_CNT);
  assign rep_wrap   = vga_frame_end && (rep_q == REP_LAST);
  assign last_frame = (ridx_q == LAST_IDX);
  assign do_swap    = ((state_q == S_FILL)  && vga_frame_end && bank_full) ||
                      ((state_q == S_PLAY)  && rep_wrap && last_frame && bank_full) ||
                      ((state_q == S_STALL) && vga_frame_end && bank_full);
  assign do_stall   = (state_q == S_PLAY) && rep_wrap && last_frame && !bank_full;

  // State register; reset drops any partial fill immediately.
  always_ff @(posedge CLK_40 or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FILL;
      S_FILL:  if (do_swap) state_d = S_PLAY;
      S_PLAY:  if (do_stall) state_d = S_STALL;
      S_STALL: if (do_swap) state_d = S_PLAY;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    cs_d   = cs_q;
    wb2_d  = wb2_q;
    rb1_d  = rb1_q;
    rb2_d  = rb2_q;
    sw_d   = 1'b0;
    ridx_d = ridx_q;
    wcnt_d = wcnt_q;
    rep_d  = rep_q;
    gap_d  = gap_q;
    urun_d = urun_q | do_stall;
    ovf_d  = ovf_q | wr_ovf;
`ifdef VIDEO_BANK_SCHED_STATS_EN
    swap_cnt_d = swap_cnt_q;
    urun_cnt_d = urun_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        cs_d   = !start;
        wb2_d  = 1'b0;
        wcnt_d = '0;
      end
      S_FILL: begin
        wcnt_d = wcnt_inc;
        cs_d   = bank_full;
      end
      S_PLAY, S_STALL: begin
        wcnt_d = wcnt_inc;
        if (gap_q != '0) gap_d = gap_q - 1'b1;
        // Hold off the PC during the post-swap gap and while the bank is full.
        cs_d = bank_full || (gap_q != '0);
        if (state_q == S_PLAY && vga_frame_end) begin
          if (rep_wrap) begin
            rep_d = '0;
            if (!last_frame) ridx_d = ridx_q + 1'b1;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (do_swap) begin
      // The bank just filled becomes the read bank; the other one is refilled.
      rb1_d  = !wb2_q;
      rb2_d  = wb2_q;
      wb2_d  = !wb2_q;
      wcnt_d = '0;
      ridx_d = '0;
      rep_d  = '0;
      sw_d   = 1'b1;
      gap_d  = GAP_LOAD;
      cs_d   = 1'b1;
`ifdef VIDEO_BANK_SCHED_STATS_EN
      swap_cnt_d = swap_cnt_q + 16'd1;
`endif
    end
`ifdef VIDEO_BANK_SCHED_STATS_EN
    if (do_stall && urun_cnt_q != 8'hFF) urun_cnt_d = urun_cnt_q + 8'd1;
`endif
  end

  // Output and counter registers.
  always_ff @(posedge CLK_40 or negedge reset) begin
    if (!reset) begin
      cs_q   <= 1'b1;
      wb2_q  <= 1'b0;
      rb1_q  <= 1'b0;
      rb2_q  <= 1'b0;
      sw_q   <= 1'b0;
      ridx_q <= '0;
      wcnt_q <= '0;
      rep_q  <= '0;
      gap_q  <= '0;
      urun_q <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef VIDEO_BANK_SCHED_STATS_EN
      swap_cnt_q <= '0;
      urun_cnt_q <= '0;
`endif
    end else begin
      cs_q   <= cs_d;
      wb2_q  <= wb2_d;
      rb1_q  <= rb1_d;
      rb2_q  <= rb2_d;
      sw_q   <= sw_d;
      ridx_q <= ridx_d;
      wcnt_q <= wcnt_d;
      rep_q  <= rep_d;
      gap_q  <= gap_d;
      urun_q <= urun_d;
      ovf_q  <= ovf_d;
`ifdef VIDEO_BANK_SCHED_STATS_EN
      swap_cnt_q <= swap_cnt_d;
      urun_cnt_q <= urun_cnt_d;
`endif
    end
  end

  assign chip_select    = cs_q;
  assign write_bank2    = wb2_q;
  assign read_bank1     = rb1_q;
  assign read_bank2     = rb2_q;
  assign switch_mode    = sw_q;
  assign read_frame_idx = ridx_q;
  assign wr_count       = wcnt_q;
  assign underrun       = urun_q;
  assign overflow       = ovf_q;
`ifdef VIDEO_BANK_SCHED_STATS_EN
  assign swap_count     = swap_cnt_q;
  assign underrun_count = urun_cnt_q;
`endif

endmodule
